// File: rtl/seg_off_multi_sync_if.sv
// Bundle of the update, delivery and handshake signals of seg_off_multi_sync.
// The master side is the microcode write path and consumer; the slave side is the synchroniser.
interface seg_off_multi_sync_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]       upd;
  logic [NUM_CH*WIDTH-1:0] new_val;
  logic [NUM_CH*WIDTH-1:0] cur_val;
  logic                    propagate;
  logic                    flush;
  logic [NUM_CH*WIDTH-1:0] out_val;
  logic [NUM_CH-1:0]       out_mask;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;

  modport master (
    output upd, new_val, cur_val, propagate, flush, out_ready,
    input  out_val, out_mask, out_valid, busy
  );

  modport slave (
    input  upd, new_val, cur_val, propagate, flush, out_ready,
    output out_val, out_mask, out_valid, busy
  );
endinterface

// File: rtl/seg_off_multi_sync.sv
// Deferred-update synchroniser: per-channel updates are held and delivered as one snapshot on propagate.
// Optional SEG_OFF_MULTI_SYNC_STATS_EN adds coalesce_cnt and stall_cnt outputs.
//
// state    | meaning
// ST_IDLE  | nothing pending, no offer outstanding
// ST_PEND  | at least one channel pending
// ST_OFFER | snapshot registered, waiting for out_ready
module seg_off_multi_sync #(
  parameter int WIDTH     = 16,
  parameter int NUM_CH    = 2,
  parameter int LAST_WINS = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  seg_off_multi_sync_if.slave  bus
`ifdef SEG_OFF_MULTI_SYNC_STATS_EN
  ,
  output logic [15:0]          coalesce_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  localparam bit LW = (LAST_WINS != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_OFFER = 2'd2
  } state_e;

  state_e                  state;
  state_e                  state_nxt;

  logic [NUM_CH-1:0]       pend;
  logic [NUM_CH-1:0]       pend_nxt;
  logic [NUM_CH*WIDTH-1:0] pval;
  logic [NUM_CH*WIDTH-1:0] pval_nxt;
  logic [NUM_CH*WIDTH-1:0] ofr_val;
  logic [NUM_CH-1:0]       ofr_mask;

  logic [NUM_CH*WIDTH-1:0] byp_val;
  logic [NUM_CH-1:0]       eff_mask;
  logic [NUM_CH-1:0]       cap;
  logic                    in_offer;
  logic                    fire;
  logic                    load_offer;

  assign in_offer   = (state == ST_OFFER);
  assign eff_mask   = pend | bus.upd;
  assign fire       = !in_offer && bus.propagate && (|eff_mask) && !bus.flush;
  assign load_offer = fire && !bus.out_ready;
  // Updates in a delivering cycle travel with the snapshot, so they are not re-captured.
  assign cap        = bus.upd & {NUM_CH{!bus.flush && !fire}};

  // Live view of the snapshot as it would be delivered this cycle.
  always_comb begin
    byp_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pend[i] && !(LW && bus.upd[i])) begin
        byp_val[i*WIDTH +: WIDTH] = pval[i*WIDTH +: WIDTH];
      end else if (bus.upd[i]) begin
        byp_val[i*WIDTH +: WIDTH] = bus.new_val[i*WIDTH +: WIDTH];
      end else begin
        byp_val[i*WIDTH +: WIDTH] = bus.cur_val[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    pend_nxt = pend;
    pval_nxt = pval;
    if (bus.flush) begin
      pend_nxt = '0;
      pval_nxt = '0;
    end else if (fire) begin
      pend_nxt = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap[i]) begin
          pend_nxt[i] = 1'b1;
          if (!pend[i] || LW) begin
            pval_nxt[i*WIDTH +: WIDTH] = bus.new_val[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.out_valid = 1'b0;
    bus.out_mask  = '0;
    bus.out_val   = byp_val;
    bus.busy      = (state != ST_IDLE) || (|pend);
    case (state)
      ST_IDLE, ST_PEND: begin
        bus.out_valid = fire;
        bus.out_mask  = fire ? eff_mask : '0;
        if (fire) begin
          state_nxt = bus.out_ready ? ST_IDLE : ST_OFFER;
        end else begin
          state_nxt = (|pend_nxt) ? ST_PEND : ST_IDLE;
        end
      end
      ST_OFFER: begin
        bus.out_val   = ofr_val;
        bus.out_valid = !bus.flush;
        bus.out_mask  = bus.flush ? '0 : ofr_mask;
        if (bus.out_ready) begin
          state_nxt = (|pend_nxt) ? ST_PEND : ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (bus.flush) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend     <= '0;
      pval     <= '0;
      ofr_val  <= '0;
      ofr_mask <= '0;
    end else begin
      pend <= pend_nxt;
      pval <= pval_nxt;
      if (bus.flush) begin
        ofr_val  <= '0;
        ofr_mask <= '0;
      end else if (load_offer) begin
        ofr_val  <= byp_val;
        ofr_mask <= eff_mask;
      end else if (in_offer && bus.out_ready) begin
        ofr_mask <= '0;
      end
    end
  end

`ifdef SEG_OFF_MULTI_SYNC_STATS_EN
  logic coal_hit;
  logic stall_hit;

  assign coal_hit  = (|(bus.upd & pend)) && !bus.flush;
  assign stall_hit = in_offer && !bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coalesce_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (coal_hit && (coalesce_cnt != 16'hFFFF)) begin
        coalesce_cnt <= coalesce_cnt + 16'd1;
      end
      if (stall_hit && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seg_off_multi_sync.sv
// Bench for seg_off_multi_sync: first-wins and last-wins instances share stimulus
// and are compared every cycle against a behavioural model of snapshot delivery.
module tb_seg_off_multi_sync;
  localparam int W = 16;
  localparam int N = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seg_off_multi_sync_if #(.WIDTH(W), .NUM_CH(N)) bus0 ();
  seg_off_multi_sync_if #(.WIDTH(W), .NUM_CH(N)) bus1 ();

`ifdef SEG_OFF_MULTI_SYNC_STATS_EN
  logic [15:0] cc0, sc0, cc1, sc1;
`endif

  seg_off_multi_sync #(.WIDTH(W), .NUM_CH(N), .LAST_WINS(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
`ifdef SEG_OFF_MULTI_SYNC_STATS_EN
    , .coalesce_cnt(cc0), .stall_cnt(sc0)
`endif
  );

  seg_off_multi_sync #(.WIDTH(W), .NUM_CH(N), .LAST_WINS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
`ifdef SEG_OFF_MULTI_SYNC_STATS_EN
    , .coalesce_cnt(cc1), .stall_cnt(sc1)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [N-1:0]   s_upd   = '0;
  logic [N*W-1:0] s_new   = '0;
  logic [N*W-1:0] s_cur   = '0;
  bit             s_prop  = 1'b0;
  bit             s_flush = 1'b0;
  bit             s_ready = 1'b0;

  // Model: per instance k (0 = first wins, 1 = last wins), per channel.
  bit         m_pend  [2][N];
  logic [W-1:0] m_pval[2][N];
  bit         m_offer [2];
  logic [W-1:0] m_oval[2][N];
  bit         m_omask [2][N];
  int         m_cc    [2];
  int         m_sc    [2];

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%h expected=%h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_offer[k] = 1'b0;
      m_cc[k] = 0;
      m_sc[k] = 0;
      for (int c = 0; c < N; c++) begin
        m_pend[k][c] = 1'b0;
        m_pval[k][c] = '0;
        m_oval[k][c] = '0;
        m_omask[k][c] = 1'b0;
      end
    end
  endtask

  task automatic model_expect(input int k, output logic [N*W-1:0] ev, output logic [N-1:0] em,
                              output bit evalid, output bit ebusy, output logic [N-1:0] eff);
    bit any_eff;
    any_eff = 1'b0;
    ev = '0;
    eff = '0;
    ebusy = m_offer[k];
    for (int c = 0; c < N; c++) begin
      eff[c] = m_pend[k][c] | s_upd[c];
      any_eff |= eff[c];
      ebusy |= m_pend[k][c];
      if (m_offer[k])
        ev[c*W +: W] = m_oval[k][c];
      else if (s_upd[c] && (k == 1 || !m_pend[k][c]))
        ev[c*W +: W] = s_new[c*W +: W];
      else if (m_pend[k][c])
        ev[c*W +: W] = m_pval[k][c];
      else
        ev[c*W +: W] = s_cur[c*W +: W];
    end
    if (m_offer[k]) begin
      evalid = !s_flush;
      for (int c = 0; c < N; c++) em[c] = evalid & m_omask[k][c];
    end else begin
      evalid = s_prop && any_eff && !s_flush;
      em = evalid ? eff : '0;
    end
  endtask

  task automatic model_capture(input int k);
    for (int c = 0; c < N; c++) begin
      if (s_upd[c]) begin
        if (!m_pend[k][c] || k == 1) m_pval[k][c] = s_new[c*W +: W];
        m_pend[k][c] = 1'b1;
      end
    end
  endtask

  task automatic check_and_step();
    logic [N*W-1:0] ev, av;
    logic [N-1:0]   em, eff, am;
    bit             evalid, ebusy, avalid, abusy, coal;
    for (int k = 0; k < 2; k++) begin
      model_expect(k, ev, em, evalid, ebusy, eff);
      av     = (k == 0) ? bus0.out_val   : bus1.out_val;
      am     = (k == 0) ? bus0.out_mask  : bus1.out_mask;
      avalid = (k == 0) ? bus0.out_valid : bus1.out_valid;
      abusy  = (k == 0) ? bus0.busy      : bus1.busy;
      chk("out_valid", k, 64'(avalid), 64'(evalid));
      chk("out_mask",  k, 64'(am),     64'(em));
      chk("out_val",   k, 64'(av),     64'(ev));
      chk("busy",      k, 64'(abusy),  64'(ebusy));
`ifdef SEG_OFF_MULTI_SYNC_STATS_EN
      chk("coalesce_cnt", k, 64'((k == 0) ? cc0 : cc1), 64'(m_cc[k]));
      chk("stall_cnt",    k, 64'((k == 0) ? sc0 : sc1), 64'(m_sc[k]));
`endif
      coal = 1'b0;
      for (int c = 0; c < N; c++) coal |= s_upd[c] & m_pend[k][c];
      if (coal && !s_flush) m_cc[k]++;
      if (m_offer[k] && !s_ready) m_sc[k]++;
      if (s_flush) begin
        m_offer[k] = 1'b0;
        for (int c = 0; c < N; c++) begin
          m_pend[k][c] = 1'b0;
          m_omask[k][c] = 1'b0;
        end
      end else if (m_offer[k]) begin
        model_capture(k);
        if (s_ready) m_offer[k] = 1'b0;
      end else if (evalid) begin
        for (int c = 0; c < N; c++) m_pend[k][c] = 1'b0;
        if (!s_ready) begin
          m_offer[k] = 1'b1;
          for (int c = 0; c < N; c++) begin
            m_oval[k][c]  = ev[c*W +: W];
            m_omask[k][c] = eff[c];
          end
        end
      end else begin
        model_capture(k);
      end
    end
  endtask

  task automatic drive_now();
    bus0.upd = s_upd;  bus0.new_val = s_new;  bus0.cur_val = s_cur;
    bus0.propagate = s_prop;  bus0.flush = s_flush;  bus0.out_ready = s_ready;
    bus1.upd = s_upd;  bus1.new_val = s_new;  bus1.cur_val = s_cur;
    bus1.propagate = s_prop;  bus1.flush = s_flush;  bus1.out_ready = s_ready;
  endtask

  task automatic cyc(input logic [N-1:0] u, input logic [N*W-1:0] nv, input bit p, input bit f, input bit r);
    @(posedge clk);
    #1;
    s_upd = u; s_new = nv; s_prop = p; s_flush = f; s_ready = r;
    drive_now();
    #3;
    check_and_step();
  endtask

  initial begin
    model_reset();
    s_cur = 32'h1000_0000;
    drive_now();
    #12;
    chk("rst_valid", 0, 64'(bus0.out_valid), 64'h0);
    chk("rst_mask",  0, 64'(bus0.out_mask),  64'h0);
    chk("rst_busy",  1, 64'(bus1.busy),      64'h0);
    chk("rst_val",   0, 64'(bus0.out_val),   64'h1000_0000);
    #5 reset_n = 1'b1;

    // Single IP update, delivered three cycles later.
    cyc(2'b01, 32'h0000_0100, 0, 0, 0);
    chk("t1_c1_valid", 0, 64'(bus0.out_valid), 64'h0);
    cyc(2'b00, '0, 0, 0, 0);
    cyc(2'b00, '0, 0, 0, 0);
    cyc(2'b00, '0, 1, 0, 1);
    chk("t1_valid", 0, 64'(bus0.out_valid), 64'h1);
    chk("t1_val",   0, 64'(bus0.out_val),   64'h1000_0100);
    chk("t1_mask",  0, 64'(bus0.out_mask),  64'h1);
    cyc(2'b00, '0, 0, 0, 0);
    chk("t1_busy", 0, 64'(bus0.busy), 64'h0);

    // Far jump across two cycles.
    cyc(2'b01, 32'h0000_0020, 0, 0, 0);
    cyc(2'b10, 32'hF000_0000, 0, 0, 0);
    chk("t2_c2_valid", 0, 64'(bus0.out_valid), 64'h0);
    cyc(2'b00, '0, 1, 0, 1);
    chk("t2_val",  0, 64'(bus0.out_val),  64'hF000_0020);
    chk("t2_mask", 1, 64'(bus1.out_mask), 64'h3);

    // Coalescing two IP updates.
    cyc(2'b01, 32'h0000_0011, 0, 0, 0);
    cyc(2'b01, 32'h0000_0022, 0, 0, 0);
    cyc(2'b00, '0, 1, 0, 1);
    chk("t3_first_wins", 0, 64'(bus0.out_val), 64'h1000_0011);
    chk("t3_last_wins",  1, 64'(bus1.out_val), 64'h1000_0022);
`ifdef SEG_OFF_MULTI_SYNC_STATS_EN
    chk("t3_coalesce", 0, 64'(cc0), 64'h1);
`endif

    // Stall: offer held three cycles, CS captured meanwhile.
    cyc(2'b01, 32'h0000_0300, 0, 0, 0);
    cyc(2'b00, '0, 1, 0, 0);
    cyc(2'b10, 32'h2000_0000, 0, 0, 0);
    chk("t4_hold1", 0, 64'(bus0.out_val), 64'h1000_0300);
    cyc(2'b00, '0, 1, 0, 0);
    cyc(2'b00, '0, 0, 0, 0);
    chk("t4_hold3", 0, 64'(bus0.out_valid), 64'h1);
    chk("t4_mask3", 0, 64'(bus0.out_mask),  64'h1);
    cyc(2'b00, '0, 0, 0, 1);
    cyc(2'b00, '0, 0, 0, 0);
    chk("t4_pend_busy", 0, 64'(bus0.busy), 64'h1);
    cyc(2'b00, '0, 1, 0, 1);
    chk("t4_mask", 0, 64'(bus0.out_mask), 64'h2);
    chk("t4_val",  0, 64'(bus0.out_val),  64'h2000_0000);
`ifdef SEG_OFF_MULTI_SYNC_STATS_EN
    chk("t4_stall", 0, 64'(sc0), 64'h3);
`endif

    // Flush during an offer and with pending bits.
    cyc(2'b01, 32'h0000_0400, 0, 0, 0);
    cyc(2'b00, '0, 1, 0, 0);
    cyc(2'b00, '0, 0, 1, 0);
    chk("t5_flush_valid", 0, 64'(bus0.out_valid), 64'h0);
    cyc(2'b00, '0, 0, 0, 0);
    chk("t5_busy", 0, 64'(bus0.busy), 64'h0);
    cyc(2'b10, 32'h5000_0000, 0, 0, 0);
    cyc(2'b01, 32'h0000_0500, 1, 1, 1);
    chk("t5_flush2_valid", 1, 64'(bus1.out_valid), 64'h0);
    cyc(2'b00, '0, 1, 0, 1);
    chk("t5_after_valid", 0, 64'(bus0.out_valid), 64'h0);
    chk("t5_after_busy",  1, 64'(bus1.busy),      64'h0);

    // Asynchronous reset in the middle of an offer.
    cyc(2'b01, 32'h0000_0600, 0, 0, 0);
    cyc(2'b00, '0, 1, 0, 0);
    cyc(2'b00, '0, 0, 0, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 0, 64'(bus0.out_valid), 64'h0);
    chk("t6_rst_busy",  0, 64'(bus0.busy),      64'h0);
    chk("t6_rst_mask",  1, 64'(bus1.out_mask),  64'h0);
    model_reset();
    #3 reset_n = 1'b1;
    cyc(2'b00, '0, 1, 0, 1);
    chk("t6_post_valid", 0, 64'(bus0.out_valid), 64'h0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      s_cur = {16'($urandom), 16'($urandom)};
      cyc(2'($urandom_range(0, 3) == 0 ? $urandom : 0) | 2'($urandom_range(0, 2) == 0 ? $urandom : 0),
          {16'($urandom), 16'($urandom)},
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 1) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
